// File: rtl/display_frame_buffer_pkg.sv
// Shared types and constants for the double-buffered digit display store.
// Contents:
//   NDIG, DIGW      - digit count and nibble width
//   commit_state_t  - commit handshake state (IDLE / ARMED)
//   digit_t         - one stored digit {dp, nibble}
package display_frame_buffer_pkg;

    localparam int NDIG = 8;
    localparam int DIGW = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } commit_state_t;

    typedef struct packed {
        logic            dp;
        logic [DIGW-1:0] nibble;
    } digit_t;

endpackage

// File: rtl/display_frame_buffer_lz_blanker.sv
// Leading-zero blanker: combinational mask of digits that must stay dark.
// Ports:
//   digits - display bank, digit 0 is rightmost
//   mask   - 1 = digit is a leading zero (never set for digit 0)
// A digit counts as "zero" only if both its nibble and dp are clear, so a
// lit decimal point stops blanking at that digit and everything to its right.
module lz_blanker
    import display_frame_buffer_pkg::*;
#(
    parameter int LZB = 1
) (
    input  digit_t [NDIG-1:0] digits,
    output logic   [NDIG-1:0] mask
);

    logic zero_above;

    always_comb begin
        mask       = '0;
        zero_above = 1'b1;
        if (LZB != 0) begin
            // Walk from the leftmost digit down; the run of zeros ends at
            // the first non-empty digit.
            for (int unsigned k = 0; k < NDIG; k++) begin
                zero_above           = zero_above & (digits[NDIG-1-k] == '0);
                mask[NDIG-1-k]       = zero_above;
            end
            mask[0] = 1'b0;
        end
    end

endmodule

// File: rtl/display_frame_buffer.sv
// Double-buffered 8-digit display store feeding the seven-segment path.
// Host writes go to a shadow bank; a commit publishes the shadow bank into
// the display bank only on a frame boundary (edge with S == 7), so the
// scanned display never shows a half-updated frame.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   wr_en/wr_addr/      - shadow-bank write of {wr_dp, wr_data} at wr_addr
//   wr_data/wr_dp
//   commit              - one-cycle publish request
//   S                   - digit select from the pixel controller
//   nibble, dp, blank   - display-bank view of digit S (combinational)
//   pending             - commit requested, swap not yet done
//   frame_start         - one-cycle pulse after a swap edge
module display_frame_buffer
    import display_frame_buffer_pkg::*;
#(
    parameter int LZB = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [2:0]      wr_addr,
    input  logic [DIGW-1:0] wr_data,
    input  logic            wr_dp,
    input  logic            commit,
    input  logic [2:0]      S,
    output logic [DIGW-1:0] nibble,
    output logic            dp,
    output logic            blank,
    output logic            pending,
    output logic            frame_start
);

    commit_state_t          state_q, state_d;
    digit_t [NDIG-1:0]      shadow_q;
    digit_t [NDIG-1:0]      display_q;
    logic                   frame_start_q;
    logic                   boundary;
    logic                   swap;
    logic   [NDIG-1:0]      blank_mask;
    digit_t                 cur;

    assign boundary = (S == 3'b111);

    // Commit FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Commit FSM: next state. A commit landing on a boundary swaps at once,
    // so the FSM never visits ARMED in that case.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (commit && !boundary) state_d = ARMED;
            ARMED: if (boundary)            state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Commit FSM: outputs
    always_comb begin
        pending = (state_q == ARMED);
        swap    = boundary && ((state_q == ARMED) || commit);
    end

    // Banks. The swap copies the pre-edge shadow, so a write on the swap
    // edge lands in shadow only and waits for the next commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q      <= '0;
            display_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            if (wr_en) shadow_q[wr_addr] <= '{dp: wr_dp, nibble: wr_data};
            if (swap)  display_q         <= shadow_q;
            frame_start_q <= swap;
        end
    end

    lz_blanker #(.LZB(LZB)) u_blank (
        .digits (display_q),
        .mask   (blank_mask)
    );

    // Zero-latency read path keeps data aligned with the anode for S.
    always_comb begin
        cur    = display_q[S];
        nibble = cur.nibble;
        dp     = cur.dp;
        blank  = blank_mask[S];
    end

    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_frame_buffer.sv
// Self-checking bench for display_frame_buffer: directed scenarios followed
// by randomized traffic, compared every cycle against a behavioural model.
module tb_display_frame_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       wr_dp;
    logic       commit;
    logic [2:0] S;
    logic [3:0] nibble, nibble0;
    logic       dp, dp0, blank, blank0, pending, pending0, frame_start, frame_start0;

    int checks = 0;
    int errors = 0;

    // model state: each digit is {dp, nibble}
    logic [4:0] shadow_m [8];
    logic [4:0] disp_m   [8];
    bit         pending_m;
    bit         fs_m;

    always #5 clk = ~clk;

    display_frame_buffer #(.LZB(1)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit), .S(S),
        .nibble(nibble), .dp(dp), .blank(blank), .pending(pending),
        .frame_start(frame_start)
    );

    display_frame_buffer #(.LZB(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_dp(wr_dp), .commit(commit), .S(S),
        .nibble(nibble0), .dp(dp0), .blank(blank0), .pending(pending0),
        .frame_start(frame_start0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t S=%0d)", tag, obs, exp, $time, S);
        end
    endtask

    // Leading-zero rule: a digit is dark if it sits left of the highest
    // non-empty digit; digit 0 always shows.
    function automatic bit exp_blank(input int s);
        int hi = 0;
        for (int i = 0; i < 8; i++)
            if (disp_m[i] != 5'd0) hi = i;
        return (s != 0) && (s > hi);
    endfunction

    task automatic model_edge();
        bit sw;
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                shadow_m[i] = 5'd0;
                disp_m[i]   = 5'd0;
            end
            pending_m = 0;
            fs_m      = 0;
        end else begin
            sw = (S == 3'd7) && (pending_m || commit);
            if (sw) disp_m = shadow_m;
            if (wr_en) shadow_m[wr_addr] = {wr_dp, wr_data};
            pending_m = sw ? 1'b0 : (pending_m || commit);
            fs_m      = sw;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("nibble",      nibble,      disp_m[S][3:0]);
        check("dp",          dp,          disp_m[S][4]);
        check("blank",       blank,       exp_blank(int'(S)));
        check("pending",     pending,     pending_m);
        check("frame_start", frame_start, fs_m);
        check("blank_nolzb", blank0,      0);
        check("nibble_nolzb", nibble0,    disp_m[S][3:0]);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        reset = 0; wr_en = 0; wr_addr = 0; wr_data = 0; wr_dp = 0; commit = 0;
    endtask

    task automatic write_dig(input logic [2:0] a, input logic [3:0] d, input logic p);
        wr_en = 1; wr_addr = a; wr_data = d; wr_dp = p;
        cycle();
        wr_en = 0;
    endtask

    // commit at S==7 then scan one full frame
    task automatic publish_and_sweep();
        S = 3'd7; commit = 1; cycle(); commit = 0;
        for (int i = 0; i < 8; i++) begin S = 3'(i); cycle(); end
    endtask

    initial begin
        idle_inputs();
        S = 0;
        for (int i = 0; i < 8; i++) begin shadow_m[i] = 'x; disp_m[i] = 'x; end
        pending_m = 0; fs_m = 0;

        // reset and sweep
        reset = 1;
        @(posedge clk); model_edge(); #1;
        cycle();
        reset = 0;
        for (int i = 0; i < 8; i++) begin S = 3'(i); cycle(); end

        // digits 1..8, commit at S=2, swap on the S=7 edge
        for (int i = 0; i < 8; i++) begin S = 3'(i); write_dig(3'(i), 4'(i + 1), 1'b0); end
        S = 2; commit = 1; cycle(); commit = 0;
        for (int i = 3; i < 8; i++) begin
            S = 3'(i);
            check("pending_armed", pending, 1);
            check("old_display", nibble, 0);
            cycle();
        end
        S = 0; #1;
        check("first_digit", nibble, 1);
        check("fs_after_swap", frame_start, 1);
        cycle();
        S = 7; #1;
        check("last_digit", nibble, 8);
        check("pending_cleared", pending, 0);
        cycle();

        // commit + write on the boundary edge: write is not in this swap
        S = 7; commit = 1; wr_en = 1; wr_addr = 0; wr_data = 4'hF; wr_dp = 0;
        cycle();
        idle_inputs();
        S = 0; #1;
        check("write_on_swap_excluded", nibble, 1);
        cycle();
        publish_and_sweep();
        S = 0; #1;
        check("write_published", nibble, 4'hF);
        cycle();

        // leading-zero blanking: 0x00000A05, then dp on digit 5
        for (int i = 0; i < 8; i++) write_dig(3'(i), 4'd0, 1'b0);
        write_dig(3'd0, 4'h5, 1'b0);
        write_dig(3'd2, 4'hA, 1'b0);
        publish_and_sweep();
        S = 3; #1; check("lzb_s3", blank, 1);
        S = 2; #1; check("lzb_s2", blank, 0);
        write_dig(3'd5, 4'd0, 1'b1);
        publish_and_sweep();
        S = 5; #1; check("lzb_dp_s5", blank, 0);
        S = 6; #1; check("lzb_dp_s6", blank, 1);
        cycle();

        // reset while ARMED cancels the commit
        write_dig(3'd3, 4'h9, 1'b1);
        S = 3; commit = 1; cycle(); commit = 0;
        S = 4; cycle();
        S = 5; reset = 1; cycle(); reset = 0;
        S = 6; #1; check("reset_cancels", pending, 0);
        cycle();
        S = 7; cycle();
        S = 0; #1; check("no_fs_after_reset", frame_start, 0);
        for (int i = 0; i < 8; i++) begin S = 3'(i); cycle(); end

        // randomized traffic with a free-running scan
        for (int n = 0; n < 3000; n++) begin
            S       = 3'(n % 8);
            reset   = ($urandom_range(0, 199) == 0);
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            wr_dp   = ($urandom_range(0, 7) == 0);
            commit  = ($urandom_range(0, 11) == 0);
            if (n % 16 == 0) S = 3'($urandom_range(0, 7));
            cycle();
        end
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
